// File: rtl/tape_pkg.sv
// ----------------------------------------------------------------------------
// tape_pkg
// Shared definitions for the tape stream player:
//   - state_t         : player FSM states
//   - FRAME_MAX_BITS  : longest frame (start + 8 data + parity + 7 stop bits)
//   - FRAME_CNT_W     : width of the frame bit counter
//   - bits_per_frame(): frame length for a given stop-bit count and parity
// ----------------------------------------------------------------------------
package tape_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam int FRAME_MAX_BITS = 17;
  // Sized from the longest frame so STOP_BITS=7 with parity still fits.
  localparam int FRAME_CNT_W    = $clog2(FRAME_MAX_BITS);

  function automatic int bits_per_frame(input int stop_bits, input bit parity);
    return 9 + stop_bits + (parity ? 1 : 0);
  endfunction

endpackage

// File: rtl/tape_bit_encoder.sv
// ----------------------------------------------------------------------------
// tape_bit_encoder
// Turns one frame bit into a square-wave cell: data=1 for H ticks, then
// data=0 for H ticks (H = HALF_SHORT for '1', HALF_LONG for '0').
// Ports:
//   clk_sys, reset_n : clock, synchronous active-low reset
//   clr              : synchronous clear (rewind)
//   en               : freeze everything while low
//   start, bit_val   : begin a new cell carrying bit_val
//   tick             : prescaled waveform tick
//   data             : serial waveform (registered)
//   done             : pulses on the tick that ends the second half
// A start in the same cycle as done chains cells back to back.
// ----------------------------------------------------------------------------
module tape_bit_encoder #(
  parameter int HALF_SHORT = 104,
  parameter int HALF_LONG  = 208
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic start,
  input  logic bit_val,
  input  logic tick,
  output logic data,
  output logic done
);

  localparam int HCW = $clog2(HALF_LONG + 1);

  logic [HCW-1:0] cnt;
  logic           cur_bit;
  logic           second;
  logic           active;
  logic [HCW-1:0] half_m1;
  logic           half_end;

  assign half_m1  = cur_bit ? HCW'(HALF_SHORT - 1) : HCW'(HALF_LONG - 1);
  assign half_end = en && tick && active && (cnt == half_m1);
  assign done     = half_end && second;

  // NOTE: sequential state is written only with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || clr) begin
      data    <= 1'b0;
      cnt     <= '0;
      cur_bit <= 1'b0;
      second  <= 1'b0;
      active  <= 1'b0;
    end else if (en) begin
      if (start) begin
        data    <= 1'b1;
        cnt     <= '0;
        cur_bit <= bit_val;
        second  <= 1'b0;
        active  <= 1'b1;
      end else if (tick && active) begin
        if (half_end) begin
          cnt <= '0;
          if (!second) begin
            second <= 1'b1;
            data   <= 1'b0;
          end else begin
            active <= 1'b0;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tape_stream_player.sv
// ----------------------------------------------------------------------------
// tape_stream_player
// Streams bytes from the tape cache RAM and serialises each one as a framed
// FSK-style waveform: start '0', 8 data bits LSB first, [odd parity],
// STOP_BITS '1' bits.
// Optional build macro: TAPE_PARITY_EN inserts an odd-parity bit (~^byte)
// after data bit 7. Port list is the same in both builds.
// Ports:
//   clk_sys, reset_n : clock, synchronous active-low reset
//   en               : motor enable, 0 pauses without losing position
//   rewind           : level, holds the player at address 0 in IDLE
//   tape_end         : address of last valid byte (inclusive)
//   tape_addr        : cache read address
//   tape_data        : cache read data, valid RD_LAT cycles after tape_addr
//   data             : serial waveform
//   playing          : high outside IDLE and DONE
//   eot              : end of tape reached
//   byte_pos         : index of the byte being serialised
// ----------------------------------------------------------------------------
module tape_stream_player
  import tape_pkg::*;
#(
  parameter int AW         = 16,
  parameter int CLK_DIV    = 16,
  parameter int HALF_SHORT = 104,
  parameter int HALF_LONG  = 208,
  parameter int STOP_BITS  = 3,
  parameter int RD_LAT     = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          en,
  input  logic          rewind,
  input  logic [AW-1:0] tape_end,
  output logic [AW-1:0] tape_addr,
  input  logic [7:0]    tape_data,
  output logic          data,
  output logic          playing,
  output logic          eot,
  output logic [AW-1:0] byte_pos
);

`ifdef TAPE_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  localparam int BPF = bits_per_frame(STOP_BITS, PARITY_ON);
  localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t                   state;
  logic [PW-1:0]            pre_cnt;
  logic [1:0]               lat_cnt;
  logic [FRAME_CNT_W-1:0]   bit_idx;
  logic [FRAME_MAX_BITS-2:0] sr;       // remaining bits, next one at [0]
  logic [FRAME_MAX_BITS-1:0] frame;
  logic                     tick;
  logic                     bit_done;
  logic                     last_bit;
  logic                     enc_start;
  logic                     enc_bit;

  // NOTE: every always_comb output is assigned a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    frame      = '1;             // stop bits and unused tail are all '1'
    frame[0]   = 1'b0;           // start bit
    frame[8:1] = tape_data;
`ifdef TAPE_PARITY_EN
    frame[9]   = ~^tape_data;
`endif
  end

  assign tick      = en && (state == S_SHIFT) && (pre_cnt == PW'(CLK_DIV - 1));
  assign last_bit  = (bit_idx == FRAME_CNT_W'(BPF - 1));
  assign enc_start = en && ((state == S_LOAD) ||
                            ((state == S_SHIFT) && bit_done && !last_bit));
  assign enc_bit   = (state == S_LOAD) ? frame[0] : sr[0];

  // Prescaler restarts outside SHIFT so every cell starts on a clean tick
  // phase; it holds while paused so resuming loses no ticks.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || rewind) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (state != S_SHIFT || pre_cnt == PW'(CLK_DIV - 1)) pre_cnt <= '0;
      else                                                 pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n || rewind) begin
      state     <= S_IDLE;
      tape_addr <= '0;
      byte_pos  <= '0;
      playing   <= 1'b0;
      eot       <= 1'b0;
      lat_cnt   <= '0;
      bit_idx   <= '0;
      sr        <= '0;
    end else if (en) begin
      case (state)
        S_IDLE: begin
          state   <= S_FETCH;
          playing <= 1'b1;
        end
        S_FETCH: begin
          tape_addr <= byte_pos;
          lat_cnt   <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == 2'(RD_LAT - 1)) state <= S_LOAD;
          else                           lat_cnt <= lat_cnt + 1'b1;
        end
        S_LOAD: begin
          sr      <= frame[FRAME_MAX_BITS-1:1];
          bit_idx <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (bit_done) begin
            if (last_bit) begin
              // >= also ends play if tape_end was lowered below byte_pos.
              if (byte_pos >= tape_end) begin
                state   <= S_DONE;
                playing <= 1'b0;
                eot     <= 1'b1;
              end else begin
                byte_pos <= byte_pos + 1'b1;
                state    <= S_FETCH;
              end
            end else begin
              sr      <= sr >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  tape_bit_encoder #(
    .HALF_SHORT (HALF_SHORT),
    .HALF_LONG  (HALF_LONG)
  ) u_enc (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (rewind),
    .en      (en),
    .start   (enc_start),
    .bit_val (enc_bit),
    .tick    (tick),
    .data    (data),
    .done    (bit_done)
  );

endmodule
